// File: rtl/branch_resolver_pkg.sv
// Shared processor package: flag bit positions, condition-code encodings
// and the branch resolver FSM state encoding.
package branch_resolver_pkg;

   // Bit positions inside the 4-bit flags word
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Condition codes carried by branch instructions
   typedef enum logic [3:0] {
      COND_AL = 4'd0,
      COND_EQ = 4'd1,
      COND_NE = 4'd2,
      COND_CS = 4'd3,
      COND_CC = 4'd4,
      COND_MI = 4'd5,
      COND_PL = 4'd6,
      COND_VS = 4'd7,
      COND_VC = 4'd8,
      COND_HI = 4'd9,
      COND_LS = 4'd10,
      COND_GE = 4'd11,
      COND_LT = 4'd12,
      COND_GT = 4'd13,
      COND_LE = 4'd14,
      COND_NV = 4'd15
   } cond_e;

   // Branch resolver FSM states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_e;

endpackage

// File: rtl/branch_resolver_cond_check.sv
// cond_check: purely combinational condition-code evaluator shared by every
// consumer of the flags register.
module cond_check
   import branch_resolver_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       taken
);

   logic z_s;
   logic n_s;
   logic c_s;
   logic v_s;

   assign z_s = flags[FLAG_Z];
   assign n_s = flags[FLAG_N];
   assign c_s = flags[FLAG_C];
   assign v_s = flags[FLAG_V];

   // Decode the condition code against the current flags
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_AL: taken = 1'b1;
         COND_EQ: taken = z_s;
         COND_NE: taken = ~z_s;
         COND_CS: taken = c_s;
         COND_CC: taken = ~c_s;
         COND_MI: taken = n_s;
         COND_PL: taken = ~n_s;
         COND_VS: taken = v_s;
         COND_VC: taken = ~v_s;
         COND_HI: taken = c_s & ~z_s;
         COND_LS: taken = ~c_s | z_s;
         COND_GE: taken = (n_s == v_s);
         COND_LT: taken = (n_s != v_s);
         COND_GT: taken = ~z_s & (n_s == v_s);
         COND_LE: taken = z_s | (n_s != v_s);
         COND_NV: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: captures a conditional branch, waits for any in-flight
// flags update to settle, then presents the taken decision and next PC on a
// valid/ready response interface. Keeps a saturating taken-branch count.
// Optional build macro BRANCH_RESOLVER_BYPASS_EN: the flags register forwards
// its pending update, so the flags are usable immediately and WAIT is skipped.
module branch_resolver
   import branch_resolver_pkg::*;
(
   input  logic        clk,
   input  logic        rst_b,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  cond,
   input  logic [15:0] target,
   input  logic [15:0] pc_next,
   input  logic [3:0]  flags_in,
   input  logic        flags_wr_en,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_taken,
   output logic [15:0] rsp_pc,
   output logic [15:0] taken_cnt
);

`ifdef BRANCH_RESOLVER_BYPASS_EN
   localparam logic BYPASS_EN = 1'b1;
`else
   localparam logic BYPASS_EN = 1'b0;
`endif

   state_e      state_q,     state_d;
   logic [3:0]  cond_q,      cond_d;
   logic [15:0] target_q,    target_d;
   logic [15:0] pc_next_q,   pc_next_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_taken_q, rsp_taken_d;
   logic [15:0] rsp_pc_q,    rsp_pc_d;
   logic [15:0] taken_cnt_q, taken_cnt_d;

   logic [3:0]  eval_cond_s;
   logic        taken_s;
   logic        stall_s;

   // In IDLE the decision uses the live request; in WAIT the captured one
   always_comb begin
      eval_cond_s = cond_q;
      if (state_q == IDLE) begin
         eval_cond_s = cond;
      end else begin
         eval_cond_s = cond_q;
      end
   end

   cond_check u_cond_check (
      .cond  (eval_cond_s),
      .flags (flags_in),
      .taken (taken_s)
   );

   // Flags are stale only while an update is in flight and not forwarded
   assign stall_s = flags_wr_en & ~BYPASS_EN;

   // Next-state, capture, decision and counter logic
   always_comb begin
      state_d     = state_q;
      cond_d      = cond_q;
      target_d    = target_q;
      pc_next_d   = pc_next_q;
      rsp_valid_d = rsp_valid_q;
      rsp_taken_d = rsp_taken_q;
      rsp_pc_d    = rsp_pc_q;
      taken_cnt_d = taken_cnt_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cond_d    = cond;
               target_d  = target;
               pc_next_d = pc_next;
               if (stall_s) begin
                  state_d = WAIT;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_taken_d = taken_s;
                  rsp_pc_d    = taken_s ? target : pc_next;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (stall_s) begin
               state_d = WAIT;
            end else begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_taken_d = taken_s;
               rsp_pc_d    = taken_s ? target_q : pc_next_q;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               if (rsp_taken_q && (taken_cnt_q != 16'hFFFF)) begin
                  taken_cnt_d = taken_cnt_q + 16'd1;
               end else begin
                  taken_cnt_d = taken_cnt_q;
               end
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= IDLE;
         cond_q      <= 4'h0;
         target_q    <= 16'h0000;
         pc_next_q   <= 16'h0000;
         rsp_valid_q <= 1'b0;
         rsp_taken_q <= 1'b0;
         rsp_pc_q    <= 16'h0000;
         taken_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         cond_q      <= cond_d;
         target_q    <= target_d;
         pc_next_q   <= pc_next_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_taken_q <= rsp_taken_d;
         rsp_pc_q    <= rsp_pc_d;
         taken_cnt_q <= taken_cnt_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_taken = rsp_taken_q;
   assign rsp_pc    = rsp_pc_q;
   assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: the stimulus process pushes the
// hand-computed response for each branch, the monitor pops and compares on
// every response handshake.
module tb_branch_resolver;

   logic        clk;
   logic        rst_b;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  cond;
   logic [15:0] target;
   logic [15:0] pc_next;
   logic [3:0]  flags_in;
   logic        flags_wr_en;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_taken;
   logic [15:0] rsp_pc;
   logic [15:0] taken_cnt;

   typedef struct packed {
      logic        taken;
      logic [15:0] pc;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] sb_cnt;
   int          tests_run;
   int          tests_failed;

`ifdef BRANCH_RESOLVER_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   branch_resolver dut (
      .clk         (clk),
      .rst_b       (rst_b),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .cond        (cond),
      .target      (target),
      .pc_next     (pc_next),
      .flags_in    (flags_in),
      .flags_wr_en (flags_wr_en),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_taken   (rsp_taken),
      .rsp_pc      (rsp_pc),
      .taken_cnt   (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every handshaked response against the scoreboard
   always @(negedge clk) begin
      if (rst_b === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_taken", {31'd0, rsp_taken}, {31'd0, e.taken});
            chk("rsp_pc", {16'd0, rsp_pc}, {16'd0, e.pc});
            chk("taken_cnt_at_hs", {16'd0, taken_cnt}, {16'd0, e.cnt});
         end
      end
   end

   // Issue one branch; wr_n cycles of flags_wr_en starting at capture.
   // f_cap is driven during the update cycles, f_late once it settles.
   task automatic do_branch(input logic [3:0] c, input logic [3:0] f_cap,
                            input logic [3:0] f_late, input int wr_n,
                            input logic [15:0] tg, input logic [15:0] pn,
                            input logic exp_taken, input int exp_lat);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("req_ready_timeout", 32'd0, 32'd1);
      e.taken = exp_taken;
      e.pc    = exp_taken ? tg : pn;
      e.cnt   = sb_cnt;
      sb_q.push_back(e);
      if (exp_taken && sb_cnt != 16'hFFFF) sb_cnt = sb_cnt + 16'd1;
      req_valid   = 1'b1;
      cond        = c;
      target      = tg;
      pc_next     = pn;
      flags_wr_en = (wr_n > 0);
      flags_in    = (wr_n > 0) ? f_cap : f_late;
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      cond        = 4'hF;
      target      = 16'hDEAD;
      pc_next     = 16'hBEEF;
      flags_wr_en = (wr_n > 1);
      flags_in    = (wr_n > 1) ? f_cap : f_late;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         n++;
         if (rsp_valid === 1'b1) break;
         @(posedge clk);
         #1;
         flags_wr_en = (n + 1 < wr_n);
         flags_in    = (n + 1 < wr_n) ? f_cap : f_late;
      end
      chk("latency", n, exp_lat);
      chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
      flags_in    = ~f_late;
      flags_wr_en = 1'b1;
      @(posedge clk);
      #1;
      flags_wr_en = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      tests_run    = 0;
      tests_failed = 0;
      sb_cnt       = 16'h0000;
      rst_b        = 1'b0;
      req_valid    = 1'b0;
      cond         = 4'h0;
      target       = 16'h0000;
      pc_next      = 16'h0000;
      flags_in     = 4'h0;
      flags_wr_en  = 1'b0;
      rsp_ready    = 1'b1;
      #12;
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_taken", {31'd0, rsp_taken}, 32'd0);
      chk("rst_rsp_pc", {16'd0, rsp_pc}, 32'd0);
      chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      rst_b = 1'b1;

      // Basic decode vectors
      do_branch(4'd1,  4'b1000, 4'b1000, 0, 16'h0100, 16'h0042, 1'b1, 1); // EQ Z=1
      chk("taken_cnt_after_first", {16'd0, taken_cnt}, 32'd1);
      do_branch(4'd13, 4'b0101, 4'b0101, 0, 16'h0200, 16'h0044, 1'b1, 1); // GT N=V
      do_branch(4'd13, 4'b0100, 4'b0100, 0, 16'h0210, 16'h0046, 1'b0, 1); // GT N!=V
      do_branch(4'd2,  4'b1000, 4'b1000, 0, 16'h0220, 16'h0048, 1'b0, 1); // NE Z=1
      do_branch(4'd9,  4'b0010, 4'b0010, 0, 16'h0230, 16'h004A, 1'b1, 1); // HI C&!Z
      do_branch(4'd10, 4'b0010, 4'b0010, 0, 16'h0240, 16'h004C, 1'b0, 1); // LS !C|Z
      do_branch(4'd12, 4'b0001, 4'b0001, 0, 16'h0250, 16'h004E, 1'b1, 1); // LT N!=V
      do_branch(4'd15, 4'b1111, 4'b1111, 0, 16'h0260, 16'h0050, 1'b0, 1); // NV
      do_branch(4'd4,  4'b0000, 4'b0000, 0, 16'h0270, 16'h0052, 1'b1, 1); // CC !C

      // Flags update in flight: stale 0000 during update, 1000 once settled
      do_branch(4'd1, 4'b0000, 4'b1000, 2, 16'h0300, 16'h0054, ~BYPASS, BYPASS ? 1 : 3);
      do_branch(4'd0, 4'b0000, 4'b0000, 1, 16'h0310, 16'h0056, 1'b1, BYPASS ? 1 : 2);

      // Consumer stalls for 5 cycles; outputs must hold, inputs ignored
      rsp_ready = 1'b0;
      do_branch(4'd5, 4'b0100, 4'b0100, 0, 16'h0400, 16'h0058, 1'b1, 1); // MI N=1
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("hold_rsp_taken", {31'd0, rsp_taken}, 32'd1);
         chk("hold_rsp_pc", {16'd0, rsp_pc}, 32'h0400);
         chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
         req_valid   = 1'b1;
         cond        = 4'd15;
         flags_in    = 4'(i);
         flags_wr_en = i[0];
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      flags_wr_en = 1'b0;
      @(negedge clk);
      chk("idle_after_hs", {31'd0, req_ready}, 32'd1);
      chk("valid_low_after_hs", {31'd0, rsp_valid}, 32'd0);

      // Saturation: preload the counter just below the ceiling
      force dut.taken_cnt_d = 16'hFFFD;
      @(posedge clk);
      #1;
      release dut.taken_cnt_d;
      sb_cnt = 16'hFFFD;
      for (int i = 0; i < 4; i++) begin
         do_branch(4'd0, 4'b0000, 4'b0000, 0, 16'h0500 + 16'(i), 16'h0060, 1'b1, 1);
      end
      @(negedge clk);
      chk("taken_cnt_saturated", {16'd0, taken_cnt}, 32'h0000FFFF);

      // Reset while waiting for flags: everything clears, nothing emerges
      @(negedge clk);
      req_valid   = 1'b1;
      cond        = 4'd0;
      target      = 16'h0600;
      pc_next     = 16'h0062;
      flags_wr_en = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #3;
      rst_b = 1'b0;
      #1;
      chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("arst_rsp_pc", {16'd0, rsp_pc}, 32'd0);
      chk("arst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
      chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
      sb_cnt = 16'h0000;
      @(negedge clk);
      rst_b       = 1'b1;
      flags_wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
      end

      // One more branch to confirm normal operation and cleared count
      do_branch(4'd6, 4'b0000, 4'b0000, 0, 16'h0700, 16'h0064, 1'b1, 1); // PL !N
      @(negedge clk);
      chk("cnt_after_rst_branch", {16'd0, taken_cnt}, 32'd1);
      chk("scoreboard_empty", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
